// File: rtl/half_adder_reg.sv
// half_adder_reg: registered multi-lane half adder with a valid flag.
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_valid               operands on i_bit1/i_bit2 are valid this cycle
//   i_bit1, i_bit2        per-lane operands (WIDTH bits)
//   o_valid               result valid, one cycle after each accepted input
//   o_sum, o_carry        per-lane XOR / AND, held while idle
//   o_carry_count         saturating count of accepted inputs with any carry
//                         (only when HALF_ADDER_STATS_EN is defined)
module half_adder_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_bit1,
    input  logic [WIDTH-1:0] i_bit2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
`ifdef HALF_ADDER_STATS_EN
    output logic [WIDTH-1:0] o_carry,
    output logic [CNT_W-1:0] o_carry_count
`else
    output logic [WIDTH-1:0] o_carry
`endif
);
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("half_adder_reg: WIDTH must be 1..64 and CNT_W 1..32");
    end
    logic [WIDTH-1:0] carry_d;
    always_comb carry_d = i_bit1 & i_bit2;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_carry <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_sum   <= i_bit1 ^ i_bit2;
                o_carry <= carry_d;
            end
        end
    end
`ifdef HALF_ADDER_STATS_EN
    // Stops at all ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_carry_count <= '0;
        else if (i_valid && |carry_d && !(&o_carry_count))
            o_carry_count <= o_carry_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_half_adder_reg.sv
// tb_half_adder_reg: scoreboard bench for half_adder_reg at WIDTH 1, 4 and 8.
module tb_half_adder_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       vin;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       v1, v4, v8;
    logic [0:0] s1, c1;
    logic [3:0] s4, c4;
    logic [7:0] s8, c8;
    int checks = 0;
    int failures = 0;
    logic [15:0] q[$];
    logic        ev;
    logic [7:0]  es, ec;
`ifdef HALF_ADDER_STATS_EN
    logic [1:0] n1, n4, n8;
    logic [1:0] en;
`endif

    always #5 clk = ~clk;

`ifdef HALF_ADDER_STATS_EN
    half_adder_reg #(.WIDTH(1), .CNT_W(2)) dut1 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8[0:0]), .i_bit2(b8[0:0]), .o_valid(v1), .o_sum(s1), .o_carry(c1), .o_carry_count(n1));
    half_adder_reg #(.WIDTH(4), .CNT_W(2)) dut4 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8[3:0]), .i_bit2(b8[3:0]), .o_valid(v4), .o_sum(s4), .o_carry(c4), .o_carry_count(n4));
    half_adder_reg #(.WIDTH(8), .CNT_W(2)) dut8 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8), .i_bit2(b8), .o_valid(v8), .o_sum(s8), .o_carry(c8), .o_carry_count(n8));
`else
    half_adder_reg #(.WIDTH(1)) dut1 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8[0:0]), .i_bit2(b8[0:0]), .o_valid(v1), .o_sum(s1), .o_carry(c1));
    half_adder_reg #(.WIDTH(4)) dut4 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8[3:0]), .i_bit2(b8[3:0]), .o_valid(v4), .o_sum(s4), .o_carry(c4));
    half_adder_reg #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_bit1(a8), .i_bit2(b8), .o_valid(v8), .o_sum(s8), .o_carry(c8));
`endif

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, let the edge happen, then compare against the model.
    task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        rst = r;
        vin = v;
        a8  = a;
        b8  = b;
        if (!r && v) q.push_back({a, b});
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            ev = 1'b0;
            es = '0;
            ec = '0;
`ifdef HALF_ADDER_STATS_EN
            en = '0;
`endif
        end else if (q.size() != 0) begin
            p  = q.pop_front();
            ev = 1'b1;
            es = p[15:8] ^ p[7:0];
            ec = p[15:8] & p[7:0];
`ifdef HALF_ADDER_STATS_EN
            if (|ec && en != 2'd3) en = en + 2'd1;
`endif
        end else begin
            ev = 1'b0;
        end
        chk("valid8", {7'b0, v8}, {7'b0, ev});
        chk("sum8", s8, es);
        chk("carry8", c8, ec);
        chk("valid4", {7'b0, v4}, {7'b0, ev});
        chk("sum4", {4'b0, s4}, {4'b0, es[3:0]});
        chk("carry4", {4'b0, c4}, {4'b0, ec[3:0]});
        chk("valid1", {7'b0, v1}, {7'b0, ev});
        chk("sum1", {7'b0, s1}, {7'b0, es[0]});
        chk("carry1", {7'b0, c1}, {7'b0, ec[0]});
`ifdef HALF_ADDER_STATS_EN
        chk("count8", {6'b0, n8}, {6'b0, en});
`endif
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        a8  = '0;
        b8  = '0;
        // Reset held two cycles; second cycle also offers (1,1) which must be dropped.
        step(1, 0, 8'h00, 8'h00);
        step(1, 1, 8'hff, 8'hff);
        step(0, 0, 8'h00, 8'h00);
        // Truth table back-to-back on lane 0.
        step(0, 1, 8'h00, 8'h00);
        step(0, 1, 8'h00, 8'h01);
        step(0, 1, 8'h01, 8'h00);
        step(0, 1, 8'h01, 8'h01);
        step(0, 0, 8'h00, 8'h00);
        // Independent lanes, then hold while idle.
        step(0, 1, 8'h0c, 8'h0a);
        step(0, 0, 8'h33, 8'h55);
        step(0, 0, 8'h00, 8'h00);
        // Reset while o_valid is high clears the registered result.
        step(0, 1, 8'hff, 8'hff);
        step(1, 1, 8'hff, 8'hff);
        step(0, 0, 8'h00, 8'h00);
        // Counter saturation: five carry inputs then one without carry.
        step(0, 1, 8'h01, 8'h01);
        step(0, 1, 8'h80, 8'h80);
        step(0, 1, 8'h0f, 8'h03);
        step(0, 1, 8'hff, 8'h01);
        step(0, 1, 8'h10, 8'h10);
        step(0, 1, 8'hf0, 8'h0f);
        step(0, 0, 8'h00, 8'h00);
        // Exhaustive 8-bit sweep with occasional idle gaps.
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(0, 15) == 0) step(0, 0, 8'($urandom), 8'($urandom));
            step(0, 1, 8'(i >> 8), 8'(i));
        end
        step(0, 0, 8'h00, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
